// File: rtl/cfg_mgmt_arbiter_if.sv
// Bundle of the two requester ports, the cfg_mgmt core port and busy status.
interface cfg_mgmt_arbiter_if;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [BE_W-1:0]   req0_be;
  logic              req0_ready;
  logic              req0_done;
  logic [DATA_W-1:0] req0_rdata;
  logic              req0_err;

  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [BE_W-1:0]   req1_be;
  logic              req1_ready;
  logic              req1_done;
  logic [DATA_W-1:0] req1_rdata;
  logic              req1_err;

  logic [ADDR_W-1:0] cfg_mgmt_addr;
  logic              cfg_mgmt_write;
  logic [DATA_W-1:0] cfg_mgmt_write_data;
  logic [BE_W-1:0]   cfg_mgmt_byte_enable;
  logic              cfg_mgmt_read;
  logic [DATA_W-1:0] cfg_mgmt_read_data;
  logic              cfg_mgmt_read_write_done;
  logic              busy;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata, req0_be,
    output req0_ready, req0_done, req0_rdata, req0_err,
    input  req1_valid, req1_write, req1_addr, req1_wdata, req1_be,
    output req1_ready, req1_done, req1_rdata, req1_err,
    output cfg_mgmt_addr, cfg_mgmt_write, cfg_mgmt_write_data,
    output cfg_mgmt_byte_enable, cfg_mgmt_read,
    input  cfg_mgmt_read_data, cfg_mgmt_read_write_done,
    output busy
  );

  // Environment side (requesters plus core)
  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata, req0_be,
    input  req0_ready, req0_done, req0_rdata, req0_err,
    output req1_valid, req1_write, req1_addr, req1_wdata, req1_be,
    input  req1_ready, req1_done, req1_rdata, req1_err,
    input  cfg_mgmt_addr, cfg_mgmt_write, cfg_mgmt_write_data,
    input  cfg_mgmt_byte_enable, cfg_mgmt_read,
    output cfg_mgmt_read_data, cfg_mgmt_read_write_done,
    input  busy
  );
endinterface

// File: rtl/cfg_mgmt_arbiter.sv
// Two-port round-robin arbiter in front of a cfg_mgmt core, with per-access timeout.
module cfg_mgmt_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              aclk,
  input  logic              areset,
  cfg_mgmt_arbiter_if.slave bus
);

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_last;
  logic              r_owner;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_err0;
  logic              r_err1;

  logic              w_grant_vld;
  logic              w_grant;
  logic              w_done;
  logic              w_timeout;
  logic              w_finish;
  logic [DATA_W-1:0] w_result;
  logic              w_result_err;

  // Core completion only counts while a strobe is out; done beats timeout
  assign w_done    = (r_state == S_BUSY) && bus.cfg_mgmt_read_write_done;
  assign w_timeout = (r_state == S_BUSY) && !bus.cfg_mgmt_read_write_done &&
                     (r_cnt == CNT_LAST);
  assign w_finish  = w_done || w_timeout;

  // Round-robin pick: on a tie the requester not granted last wins
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = 1'b0;
    if ((r_state == S_IDLE) && !areset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_grant_vld = 1'b1;
        w_grant     = ~r_last;
      end else if (bus.req0_valid) begin
        w_grant_vld = 1'b1;
      end else if (bus.req1_valid) begin
        w_grant_vld = 1'b1;
        w_grant     = 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_vld) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_finish) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result presented to the owner: core data on completion, all-ones on timeout
  always_comb begin
    w_result     = '1;
    w_result_err = 1'b1;
    if (w_done) begin
      w_result     = r_write ? '0 : bus.cfg_mgmt_read_data;
      w_result_err = 1'b0;
    end
  end

  // State register
  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Request capture, timeout counter and per-requester result registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_cnt    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
    end else begin
      if (w_grant_vld) begin
        r_owner <= w_grant;
        r_last  <= w_grant;
        r_cnt   <= '0;
        if (w_grant) begin
          r_write <= bus.req1_write;
          r_addr  <= bus.req1_addr;
          r_wdata <= bus.req1_wdata;
          r_be    <= bus.req1_be;
        end else begin
          r_write <= bus.req0_write;
          r_addr  <= bus.req0_addr;
          r_wdata <= bus.req0_wdata;
          r_be    <= bus.req0_be;
        end
      end else if ((r_state == S_BUSY) && !bus.cfg_mgmt_read_write_done) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_finish) begin
        if (r_owner) begin
          r_rdata1 <= w_result;
          r_err1   <= w_result_err;
        end else begin
          r_rdata0 <= w_result;
          r_err0   <= w_result_err;
        end
      end
    end
  end

  assign bus.req0_ready = w_grant_vld && !w_grant;
  assign bus.req1_ready = w_grant_vld && w_grant;
  assign bus.req0_done  = !areset && (r_state == S_RESP) && !r_owner;
  assign bus.req1_done  = !areset && (r_state == S_RESP) && r_owner;
  assign bus.req0_rdata = r_rdata0;
  assign bus.req1_rdata = r_rdata1;
  assign bus.req0_err   = r_err0;
  assign bus.req1_err   = r_err1;

  assign bus.cfg_mgmt_write       = !areset && (r_state == S_BUSY) && r_write;
  assign bus.cfg_mgmt_read        = !areset && (r_state == S_BUSY) && !r_write;
  assign bus.cfg_mgmt_addr        = r_addr;
  assign bus.cfg_mgmt_write_data  = r_wdata;
  assign bus.cfg_mgmt_byte_enable = r_be;
  assign bus.busy                 = !areset && (r_state != S_IDLE);

endmodule

// File: tb/tb_cfg_mgmt_arbiter.sv
// Bench for cfg_mgmt_arbiter: directed vector table, corner sequences, random run vs model.
module tb_cfg_mgmt_arbiter;
  localparam int unsigned T    = 4;
  localparam int          NCYC = 2000;

  logic aclk;
  logic areset;
  cfg_mgmt_arbiter_if bus ();

  cfg_mgmt_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_rd [2];
  logic        exp_er [2];

  typedef struct {
    bit          req;
    bit          wr;
    logic [18:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          dly;        // strobe cycles before core done; -1 = never
    logic [31:0] core;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_strobes;
  } vec_t;
  vec_t vecs [7];

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic w, input logic [18:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_write = w; bus.req0_addr = a;
      bus.req0_wdata = d; bus.req0_be = b;
    end else begin
      bus.req1_valid = v; bus.req1_write = w; bus.req1_addr = a;
      bus.req1_wdata = d; bus.req1_be = b;
    end
  endtask

  task automatic idle_inputs();
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    bus.cfg_mgmt_read_write_done = 1'b0;
    bus.cfg_mgmt_read_data       = '0;
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    areset = 1'b1;
    idle_inputs();
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    areset = 1'b0;
    for (int i = 0; i < 2; i++) begin exp_rd[i] = '0; exp_er[i] = 1'b0; end
  endtask

  task automatic run_vec(input vec_t v);
    int   strobes;
    bit   got;
    logic own_done, oth_done;
    strobes = 0;
    got     = 0;
    @(posedge aclk); #1;
    set_req(int'(v.req), 1'b1, v.wr, v.addr, v.wdata, v.be);
    bus.cfg_mgmt_read_write_done = 1'b0;
    @(negedge aclk);
    chk("vec_ready", 64'({bus.req1_ready, bus.req0_ready}), v.req ? 64'd2 : 64'd1);
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge aclk); #1;
      if (c == 1) set_req(int'(v.req), 1'b0, 1'b0, '0, '0, '0);
      bus.cfg_mgmt_read_write_done = (v.dly >= 0) && (c == 1 + v.dly);
      bus.cfg_mgmt_read_data = bus.cfg_mgmt_read_write_done ? v.core : $urandom;
      @(negedge aclk);
      if (bus.cfg_mgmt_read || bus.cfg_mgmt_write) begin
        strobes++;
        chk("vec_strobe", 64'({bus.cfg_mgmt_write, bus.cfg_mgmt_read, bus.cfg_mgmt_addr,
                               bus.cfg_mgmt_write_data, bus.cfg_mgmt_byte_enable}),
            64'({v.wr, ~v.wr, v.addr, v.wdata, v.be}));
      end
      own_done = v.req ? bus.req1_done : bus.req0_done;
      oth_done = v.req ? bus.req0_done : bus.req1_done;
      chk("vec_other_done", 64'(oth_done), 64'd0);
      if (own_done) begin
        got = 1;
        chk("vec_rdata", 64'(v.req ? bus.req1_rdata : bus.req0_rdata), 64'(v.exp_rdata));
        chk("vec_err", 64'(v.req ? bus.req1_err : bus.req0_err), 64'(v.exp_err));
      end
    end
    chk("vec_got_done", 64'(got), 64'd1);
    chk("vec_strobes", 64'(strobes), 64'(v.exp_strobes));
    chk("vec_other_hold", 64'({v.req ? bus.req0_rdata : bus.req1_rdata,
                               v.req ? bus.req0_err : bus.req1_err}),
        64'({exp_rd[!v.req], exp_er[!v.req]}));
    exp_rd[v.req] = v.exp_rdata;
    exp_er[v.req] = v.exp_err;
    @(posedge aclk); #1;
    bus.cfg_mgmt_read_write_done = 1'b0;
    @(negedge aclk);
    chk("vec_idle_after", 64'({bus.busy, bus.req0_done, bus.req1_done}), 64'd0);
  endtask

  // Random-phase model state
  logic        pv [2];
  logic        pw [2];
  logic [18:0] pa [2];
  logic [31:0] pd [2];
  logic [3:0]  pb [2];
  int          t_acc, len, dly, free_at, accepts, dones;
  bit          m_last, own, c_wr, win, in_win, pulse;
  logic [18:0] c_a;
  logic [31:0] c_d, core_rd;
  logic [3:0]  c_b;
  logic [1:0]  exp_r;

  initial begin
    areset = 1'b1;
    idle_inputs();

    // Reset: everything low, even with a request and a stray done present
    @(posedge aclk); #1;
    bus.req0_valid = 1'b1;
    bus.cfg_mgmt_read_write_done = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("rst_ctrl", 64'({bus.req0_ready, bus.req1_ready, bus.req0_done, bus.req1_done,
                         bus.cfg_mgmt_write, bus.cfg_mgmt_read, bus.busy,
                         bus.req0_err, bus.req1_err}), 64'd0);
    chk("rst_rdata", 64'({bus.req0_rdata, bus.req1_rdata}), 64'd0);
    chk("rst_bus", 64'({bus.cfg_mgmt_addr, bus.cfg_mgmt_write_data,
                        bus.cfg_mgmt_byte_enable}), 64'd0);
    do_reset();

    // Directed vectors
    vecs[0] = '{0, 0, 19'h00010, 32'h0,         4'hF, 2,  32'hCAFE_0001, 32'hCAFE_0001, 0, 3};
    vecs[1] = '{1, 1, 19'h00404, 32'h1234_5678, 4'h3, 1,  32'hDEAD_BEEF, 32'h0,         0, 2};
    vecs[2] = '{0, 0, 19'h7FFFF, 32'h0,         4'hF, -1, 32'h0,         32'hFFFF_FFFF, 1, 4};
    vecs[3] = '{1, 0, 19'h00020, 32'h0,         4'hF, 3,  32'h0BAD_F00D, 32'h0BAD_F00D, 0, 4};
    vecs[4] = '{0, 1, 19'h12345, 32'hA5A5_5A5A, 4'hC, 0,  32'h7777_7777, 32'h0,         0, 1};
    vecs[5] = '{1, 1, 19'h00001, 32'hFFFF_0000, 4'h1, -1, 32'h0,         32'hFFFF_FFFF, 1, 4};
    vecs[6] = '{0, 0, 19'h40000, 32'h0,         4'h8, 0,  32'h5555_AAAA, 32'h5555_AAAA, 0, 1};
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Stray done while idle: ignored, results hold
    for (int c = 0; c < 5; c++) begin
      @(posedge aclk); #1;
      bus.cfg_mgmt_read_write_done = 1'b1;
      bus.cfg_mgmt_read_data = $urandom;
      @(negedge aclk);
      chk("stray_ctrl", 64'({bus.busy, bus.req0_done, bus.req1_done,
                             bus.cfg_mgmt_read, bus.cfg_mgmt_write}), 64'd0);
      chk("stray_hold", 64'({bus.req0_rdata, bus.req1_rdata}), {exp_rd[0], exp_rd[1]});
    end
    bus.cfg_mgmt_read_write_done = 1'b0;

    // Contention: both valid, core completes immediately; grants alternate every 3 cycles
    do_reset();
    begin
      int n, last_c;
      n = 0;
      last_c = 0;
      set_req(0, 1'b1, 1'b0, 19'h00100, 32'h0, 4'hF);
      set_req(1, 1'b1, 1'b1, 19'h00200, 32'h1111_2222, 4'hF);
      for (int c = 0; c < 40 && n < 4; c++) begin
        if (c > 0) begin
          @(posedge aclk); #1;
        end
        bus.cfg_mgmt_read_write_done = bus.cfg_mgmt_read | bus.cfg_mgmt_write;
        bus.cfg_mgmt_read_data = $urandom;
        @(negedge aclk);
        chk("cont_both_ready", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
        if (bus.req0_ready || bus.req1_ready) begin
          chk("cont_grant", 64'(bus.req1_ready), 64'(n % 2));
          if (n > 0) chk("cont_spacing", 64'(c - last_c), 64'd3);
          last_c = c;
          n++;
        end
      end
      chk("cont_grants", 64'(n), 64'd4);
      idle_inputs();
      repeat (4) @(posedge aclk);
    end

    // Reset in the middle of a read: abort silently, then req0 priority again
    do_reset();
    @(posedge aclk); #1;
    set_req(1, 1'b1, 1'b0, 19'h00123, 32'h0, 4'hF);
    @(negedge aclk);
    chk("mid_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'd2);
    @(posedge aclk); #1;
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge aclk);
    chk("mid_strobe_on", 64'(bus.cfg_mgmt_read), 64'd1);
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("mid_after_rst", 64'({bus.cfg_mgmt_read, bus.cfg_mgmt_write, bus.busy,
                              bus.req0_done, bus.req1_done}), 64'd0);
    chk("mid_rdata", 64'({bus.req1_rdata, bus.req1_err}), 64'd0);
    for (int c = 0; c < 6; c++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("mid_no_done", 64'({bus.req0_done, bus.req1_done, bus.busy}), 64'd0);
    end
    @(posedge aclk); #1;
    set_req(0, 1'b1, 1'b0, 19'h00055, 32'h0, 4'hF);
    set_req(1, 1'b1, 1'b1, 19'h00066, 32'h2222_3333, 4'hF);
    @(negedge aclk);
    chk("mid_prio", 64'({bus.req1_ready, bus.req0_ready}), 64'd1);
    @(posedge aclk); #1;
    idle_inputs();
    bus.cfg_mgmt_read_write_done = 1'b1;
    bus.cfg_mgmt_read_data = 32'h1357_9BDF;
    @(negedge aclk);
    chk("mid_strobe2", 64'({bus.cfg_mgmt_read, bus.cfg_mgmt_addr}), 64'({1'b1, 19'h00055}));
    @(posedge aclk); #1;
    bus.cfg_mgmt_read_write_done = 1'b0;
    @(negedge aclk);
    chk("mid_done", 64'({bus.req0_done, bus.req1_done, bus.req0_err}), 64'({3'b100}));
    chk("mid_done_rdata", 64'(bus.req0_rdata), 64'h1357_9BDF);

    // Random traffic against a transaction-timing model
    do_reset();
    for (int i = 0; i < 2; i++) begin
      pv[i] = 0; pw[i] = 0; pa[i] = '0; pd[i] = '0; pb[i] = '0;
    end
    t_acc = -100; len = 0; dly = 0; free_at = 0; accepts = 0; dones = 0;
    m_last = 1; own = 0; c_wr = 0; c_a = '0; c_d = '0; c_b = '0; core_rd = '0;
    for (int cyc = 0; cyc < NCYC + 30; cyc++) begin
      @(posedge aclk); #1;
      for (int i = 0; i < 2; i++) begin
        if (cyc >= NCYC) pv[i] = 0;
        else if (!pv[i]) begin
          if ($urandom_range(1) == 1) begin
            pv[i] = 1; pw[i] = 1'($urandom); pa[i] = 19'($urandom);
            pd[i] = $urandom; pb[i] = 4'($urandom);
          end
        end else if ($urandom_range(7) == 0) pv[i] = 0;
        set_req(i, pv[i], pw[i], pa[i], pd[i], pb[i]);
      end
      in_win = (cyc > t_acc) && (cyc <= t_acc + len);
      bus.cfg_mgmt_read_data = $urandom;
      if (in_win && (cyc == t_acc + 1 + dly)) begin
        bus.cfg_mgmt_read_write_done = 1'b1;
        core_rd = bus.cfg_mgmt_read_data;
      end else begin
        bus.cfg_mgmt_read_write_done = !in_win && ($urandom_range(7) == 0);
      end
      @(negedge aclk);
      chk("rnd_strobe", 64'({bus.cfg_mgmt_write, bus.cfg_mgmt_read}),
          in_win ? 64'({c_wr, ~c_wr}) : 64'd0);
      if (in_win)
        chk("rnd_fields", 64'({bus.cfg_mgmt_addr, bus.cfg_mgmt_write_data,
                               bus.cfg_mgmt_byte_enable}), 64'({c_a, c_d, c_b}));
      chk("rnd_busy", 64'(bus.busy), 64'((cyc > t_acc) && (cyc <= t_acc + len + 1)));
      pulse = (cyc == t_acc + len + 1);
      chk("rnd_done", 64'({bus.req1_done, bus.req0_done}),
          pulse ? (own ? 64'd2 : 64'd1) : 64'd0);
      if (pulse) begin
        dones++;
        chk("rnd_result", 64'(own ? {bus.req1_err, bus.req1_rdata} : {bus.req0_err, bus.req0_rdata}),
            (dly >= int'(T)) ? 64'({1'b1, 32'hFFFF_FFFF})
                             : 64'({1'b0, c_wr ? 32'h0 : core_rd}));
      end
      exp_r = 2'b00;
      if ((cyc >= free_at) && (pv[0] || pv[1])) begin
        win   = (pv[0] && pv[1]) ? ~m_last : pv[1];
        exp_r = win ? 2'b10 : 2'b01;
      end
      chk("rnd_ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(exp_r));
      if (exp_r != 2'b00) begin
        m_last = win; own = win;
        c_wr = pw[win]; c_a = pa[win]; c_d = pd[win]; c_b = pb[win];
        dly = int'($urandom_range(T + 2));
        t_acc = cyc;
        len = (dly < int'(T)) ? dly + 1 : int'(T);
        free_at = cyc + len + 2;
        pv[win] = 0;
        accepts++;
      end
    end
    chk("rnd_accounting", 64'(dones), 64'(accepts));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
